// File: rtl/runctl_pkg.sv
// Shared definitions for the run controller: FSM state encoding and datapath widths.
package runctl_pkg;
  localparam int LEN_W = 3;
  localparam int Q_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, combinational; a tie goes to the requester not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_b,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_b ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: rtl/run_controller.sv
// Arbitrated burst controller: clear, run for Len+1 cycles, one-cycle done; all outputs registered.
// RUNCTL_QCHECK_EN adds a shadow counter that checks {QA,QB} and flags mismatches on QErr.
module run_controller
  import runctl_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ReqA,
  input  logic             ReqB,
  input  logic [LEN_W-1:0] LenA,
  input  logic [LEN_W-1:0] LenB,
  input  logic             QA,
  input  logic             QB,
  output logic             Run,
  output logic             CntClr,
  output logic             GntA,
  output logic             GntB,
  output logic             Busy,
  output logic             Done,
  output logic             Short,
  output logic             QErr
);
  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             last_b_q, last_b_d;
  logic             run_q, run_d;
  logic             clr_q, clr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             short_q, short_d;
  logic [1:0]       arb_gnt;
  logic             granted_req;

  rr_arb2 u_arb (
    .req    ({ReqB, ReqA}),
    .last_b (last_b_q),
    .gnt    (arb_gnt)
  );

  assign granted_req = |(gnt_q & {ReqB, ReqA});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    last_b_d = last_b_q;
    short_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          state_d = CLEAR;
          gnt_d   = arb_gnt;
          cnt_d   = arb_gnt[1] ? LenB : LenA;
        end
      end
      CLEAR: begin
        if (!granted_req) begin
          state_d = DONE;
          short_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A dropped request wins over normal completion so the abort is always reported.
        if (!granted_req) begin
          state_d = DONE;
          short_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      DONE: begin
        state_d  = IDLE;
        gnt_d    = 2'b00;
        last_b_d = gnt_q[1];
      end
      default: state_d = IDLE;
    endcase
    run_d  = (state_d == RUN);
    clr_d  = (state_d == CLEAR);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= 2'b00;
      last_b_q <= 1'b1;
      run_q    <= 1'b0;
      clr_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      last_b_q <= last_b_d;
      run_q    <= run_d;
      clr_q    <= clr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      short_q  <= short_d;
    end
  end

`ifdef RUNCTL_QCHECK_EN
  logic [Q_W-1:0] shadow_q, shadow_d;
  logic           qerr_q, qerr_d;

  // Shadow tracks what the counter should read: zero after CLEAR, +1 per Run cycle.
  always_comb begin
    shadow_d = shadow_q;
    qerr_d   = qerr_q;
    if (state_q == CLEAR) begin
      shadow_d = '0;
    end else if (run_q) begin
      shadow_d = shadow_q + Q_W'(1);
    end
    if (state_d == CLEAR) begin
      qerr_d = 1'b0;
    end else if ((state_q == RUN || state_q == DONE) && ({QA, QB} != shadow_q)) begin
      qerr_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadow_q <= '0;
      qerr_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      qerr_q   <= qerr_d;
    end
  end

  assign QErr = qerr_q;
`else
  logic unused_qin;
  assign unused_qin = QA ^ QB;
  assign QErr       = 1'b0;
`endif

  assign Run    = run_q;
  assign CntClr = clr_q;
  assign GntA   = gnt_q[0];
  assign GntB   = gnt_q[1];
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Short  = short_q;
endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: burst table plus reset and counter-check sequences, with a per-cycle scoreboard.
module tb_run_controller;
  logic       Clk = 1'b0;
  logic       Reset, ReqA, ReqB;
  logic [2:0] LenA, LenB;
  logic       QA, QB;
  logic       Run, CntClr, GntA, GntB, Busy, Done, Short, QErr;

  run_controller dut (
    .Clk(Clk), .Reset(Reset), .ReqA(ReqA), .ReqB(ReqB), .LenA(LenA), .LenB(LenB),
    .QA(QA), .QB(QB), .Run(Run), .CntClr(CntClr), .GntA(GntA), .GntB(GntB),
    .Busy(Busy), .Done(Done), .Short(Short), .QErr(QErr)
  );

  always #5 Clk = ~Clk;

  // Model of the external 2-bit counter datapath, with an optional stuck-at-0 LSB.
  logic [1:0] q_model;
  logic       stuck_qb;
  always @(posedge Clk) begin
    if (Reset)       q_model <= 2'b00;
    else if (CntClr) q_model <= 2'b00;
    else if (Run)    q_model <= q_model + 2'b01;
  end
  assign QA = q_model[1];
  assign QB = stuck_qb ? 1'b0 : q_model[0];

`ifdef RUNCTL_QCHECK_EN
  localparam int STUCK_ERR_RUN = 2;
`else
  localparam int STUCK_ERR_RUN = 0;
`endif

  typedef struct packed {
    logic run, clr, ga, gb, busy, done, shrt, qerr;
  } obs_t;

  typedef struct {
    logic       ra, rb;
    logic [2:0] la, lb;
    int         drop;   // 0 none, 1..8 drop in that Run cycle, 15 drop during CLEAR
    logic       exp_b;
    int         exp_n;  // expected Run cycles
  } vec_t;

  obs_t exp_q[$];
  vec_t tbl[12];
  int   total = 0;
  int   bad   = 0;

  function automatic obs_t mk(logic run, logic clr, logic ga, logic gb, logic busy,
                              logic done, logic shrt, logic qerr);
    obs_t o;
    o = {run, clr, ga, gb, busy, done, shrt, qerr};
    return o;
  endfunction

  task automatic compare_now(string tag);
    obs_t a, e;
    a = {Run, CntClr, GntA, GntB, Busy, Done, Short, QErr};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got {run,clr,ga,gb,busy,done,short,qerr}=%b", tag, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got {run,clr,ga,gb,busy,done,short,qerr}=%b want %b", tag, a, e);
      end
    end
  endtask

  task automatic check_cycle(string tag);
    @(posedge Clk);
    #1;
    compare_now(tag);
  endtask

  // Called in an IDLE cycle; drives the request and checks every cycle up to the following IDLE.
  task automatic run_burst(vec_t v, int err_run, string tag);
    logic ga, gb, sh, qe, dropnow;
    int   n;
    gb = v.exp_b;
    ga = ~v.exp_b;
    n  = v.exp_n;
    sh = (v.drop != 0);
    ReqA = v.ra; ReqB = v.rb; LenA = v.la; LenB = v.lb;
    exp_q.push_back(mk(0, 1, ga, gb, 1, 0, 0, 0));
    for (int k = 1; k <= n; k++) begin
      qe = (err_run != 0) && (k > err_run);
      exp_q.push_back(mk(1, 0, ga, gb, 1, 0, 0, qe));
    end
    qe = (err_run != 0);
    exp_q.push_back(mk(0, 0, ga, gb, 1, 1, sh, qe));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, qe));
    for (int c = 1; c <= n + 3; c++) begin
      check_cycle($sformatf("%s c%0d", tag, c));
      if (c < n + 2) begin
        LenA = 3'($urandom_range(0, 7));
        LenB = 3'($urandom_range(0, 7));
        if (gb) ReqA = 1'($urandom_range(0, 1));
        else    ReqB = 1'($urandom_range(0, 1));
      end
      dropnow = (v.drop == 15 && c == 1) || (v.drop != 0 && v.drop != 15 && c - 1 == v.drop);
      if (dropnow) begin
        if (gb) ReqB = 1'b0;
        else    ReqA = 1'b0;
      end
      if (c == n + 2) begin
        ReqA = 1'b0;
        ReqB = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 3'd2, 3'd5, 0,  1'b0, 3};
    tbl[1]  = '{1'b1, 1'b1, 3'd0, 3'd0, 0,  1'b1, 1};
    tbl[2]  = '{1'b1, 1'b1, 3'd0, 3'd0, 0,  1'b0, 1};
    tbl[3]  = '{1'b1, 1'b1, 3'd0, 3'd0, 0,  1'b1, 1};
    tbl[4]  = '{1'b1, 1'b1, 3'd0, 3'd0, 0,  1'b0, 1};
    tbl[5]  = '{1'b0, 1'b1, 3'd6, 3'd7, 3,  1'b1, 3};
    tbl[6]  = '{1'b1, 1'b0, 3'd7, 3'd0, 0,  1'b0, 8};
    tbl[7]  = '{1'b1, 1'b1, 3'd3, 3'd1, 0,  1'b1, 2};
    tbl[8]  = '{1'b0, 1'b1, 3'd2, 3'd4, 0,  1'b1, 5};
    tbl[9]  = '{1'b1, 1'b1, 3'd1, 3'd6, 1,  1'b0, 1};
    tbl[10] = '{1'b0, 1'b1, 3'd0, 3'd2, 15, 1'b1, 0};
    tbl[11] = '{1'b1, 1'b1, 3'd4, 3'd4, 0,  1'b0, 5};

    stuck_qb = 1'b0;
    Reset = 1'b1; ReqA = 1'b0; ReqB = 1'b0; LenA = 3'd0; LenB = 3'd0;
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    compare_now("reset_state");
    Reset = 1'b0;
    repeat (2) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      check_cycle("idle_no_req");
    end

    for (int i = 0; i < 12; i++) begin
      run_burst(tbl[i], 0, $sformatf("vec%0d", i));
    end

    // Reset in the 4th Run cycle of a long A burst; pointer must return to favouring A.
    ReqA = 1'b1; ReqB = 1'b0; LenA = 3'd7;
    exp_q.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0));
    repeat (4) exp_q.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0));
    for (int c = 1; c <= 5; c++) check_cycle($sformatf("pre_reset c%0d", c));
    Reset = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    check_cycle("mid_burst_reset");
    Reset = 1'b0;
    run_burst('{1'b1, 1'b1, 3'd0, 3'd0, 0, 1'b0, 1}, 0, "post_reset_tie");

    // Counter checking: stuck LSB, then a clean burst whose CLEAR must clear QErr.
    run_burst('{1'b1, 1'b0, 3'd5, 3'd0, 0, 1'b0, 6}, 0, "q_clean");
    stuck_qb = 1'b1;
    run_burst('{1'b1, 1'b0, 3'd5, 3'd0, 0, 1'b0, 6}, STUCK_ERR_RUN, "q_stuck");
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, (STUCK_ERR_RUN != 0)));
    check_cycle("q_sticky_idle");
    stuck_qb = 1'b0;
    run_burst('{1'b1, 1'b0, 3'd5, 3'd0, 0, 1'b0, 6}, 0, "q_recover");

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 The block SHALL use one clock, Clk, and a synchronous, active-high reset, Reset.
REQ-002 Ports SHALL be as follows; clock and reset come first, and no parameters are defined.
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous active-high reset.
- ReqA  in  1  requester A wants the counter datapath; level signal.
- ReqB  in  1  requester B wants the counter datapath; level signal.
- LenA  in  3  burst length for A; Run is held for LenA+1 cycles.
- LenB  in  3  burst length for B; Run is held for LenB+1 cycles.
- QA  in  1  counter state bit, MSB.
- QB  in  1  counter state bit, LSB.
- Run  out  1  count enable to the counter datapath.
- CntClr  out  1  synchronous clear to the counter, forcing QA,QB to 00.
- GntA  out  1  requester A owns the datapath.
- GntB  out  1  requester B owns the datapath.
- Busy  out  1  a burst is in progress (any state other than IDLE).
- Done  out  1  one-cycle burst-complete pulse.
- Short  out  1  qualifies Done: the burst was cut short by a request drop.
- QErr  out  1  sticky counter-mismatch flag (see Configuration).

Function
REQ-003 The FSM SHALL have four states: IDLE, CLEAR, RUN, DONE.
REQ-004 In IDLE with ReqA or ReqB high, the FSM SHALL grant one requester, latch its Len into the remaining-count register and go to CLEAR; otherwise it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin.
- Only one request high: that requester is granted.
- Both high: the requester not granted last wins.
- Pointer after reset favours A.
REQ-006 CLEAR SHALL last exactly 1 cycle: CntClr=1, Run=0. It then goes to RUN.
REQ-007 In RUN, Run SHALL be 1 and the remaining count SHALL decrement by 1 each cycle.
- Exit to DONE after the cycle in which the count equals 0.
- Total Run cycles = Len+1 (1..8).
REQ-008 If the granted Req deasserts during RUN, Run SHALL drop in the next cycle and the FSM SHALL enter DONE with Short=1; a Req drop in CLEAR SHALL be treated the same way.
REQ-009 DONE SHALL last 1 cycle with Done=1 and Run=0; it then updates the round-robin pointer to the granted requester and returns to IDLE.
REQ-010 Grant SHALL behave as follows.
- GntA/GntB are registered and one-hot or zero.
- The grant asserts on entry to CLEAR and holds through DONE.
- The grant deasserts on return to IDLE.
REQ-011 Latency SHALL be fixed.
- Req rises while IDLE in cycle t: Gnt and CntClr in t+1, Run in t+2..t+2+Len, Done in t+3+Len.
- Back-to-back bursts have at least 1 IDLE cycle between them.
REQ-012 Req and Len changes outside IDLE SHALL be ignored; the one exception is the drop of the granted Req per REQ-008.
REQ-013 Busy SHALL be 1 in CLEAR, RUN and DONE.
REQ-014 All outputs SHALL be registered.

Reset
REQ-015 Reset SHALL have priority over all other inputs, including mid-burst, and SHALL apply at the next rising edge.
- State goes to IDLE; round-robin pointer favours A; remaining count = 0.
- Run, CntClr, GntA, GntB, Busy, Done, Short and QErr are all 0.
REQ-016 Reset SHALL NOT assert CntClr; the counter datapath takes Reset directly.

Configuration
REQ-017 The macro RUNCTL_QCHECK_EN SHALL control counter checking.
- Defined: a 2-bit shadow counter is cleared in CLEAR and increments (wrapping 11->00) on each Run cycle.
- Defined: in every cycle of RUN and DONE, {QA,QB} is compared with the shadow; any mismatch sets QErr.
- Defined: QErr is cleared only by Reset or on entry to CLEAR.
- Undefined: the shadow counter and compare logic are absent, QErr is tied to 0, and QA/QB are unused.

Structure
REQ-018 The package runctl_pkg SHALL hold the shared definitions.
- FSM state enum: IDLE, CLEAR, RUN, DONE.
- LEN_W=3.
- Q_W=2.
REQ-019 Arbitration SHALL be in a sub-module rr_arb2: 2 requests, a last-grant pointer input, and a one-hot grant output (combinational). Its grant is registered by run_controller.

Verification
REQ-020 Single request: ReqA=1, LenA=2 in IDLE -> GntA t+1, CntClr t+1, Run t+2..t+4 (3 cycles), Done t+5, Short=0.
REQ-021 Contention: ReqA=ReqB=1 held, LenA=LenB=0 -> grants alternate A,B,A,B, each with 1 Run cycle and 1 Done pulse.
REQ-022 Abort: ReqB=1, LenB=7, ReqB drops in the 3rd Run cycle -> Run=0 from the next cycle, then Done=1 with Short=1, GntB=0 after DONE.
REQ-023 Mid-burst reset: Reset=1 in the 4th Run cycle -> next edge shows all outputs 0 and state IDLE; a subsequent ReqA+ReqB grants A.
REQ-024 Wrap and check (RUNCTL_QCHECK_EN defined): LenA=5 with a correct counter model -> Q sequence 01,10,11,00,01,10 and QErr=0. Forcing QB stuck-at-0 -> QErr=1 in the first mismatch's following cycle, held until the next CLEAR.
REQ-025 Macro off: same stimulus as REQ-024 -> QErr stays 0 and burst timing is identical to REQ-020 scaling.
